// File: rtl/output_layer_mac_if.sv
`default_nettype none
// ============================================================================
// Module   : output_layer_mac_if
// Brief    : Start/memory/result bundle between the output-layer MAC and its RAMs.
// Revision : 1.0
// ============================================================================
interface output_layer_mac_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 5,
    parameter int OUT_ADDR_WIDTH = 4
);
    logic                                 start_i;
    logic [ADDR_WIDTH-1:0]                hid_addr_o;
    logic [DATA_WIDTH-1:0]                hid_q_i;
    logic [OUT_ADDR_WIDTH+ADDR_WIDTH-1:0] wt_addr_o;
    logic [DATA_WIDTH-1:0]                wt_q_i;
    logic                                 busy_o;
    logic                                 out_we_o;
    logic [OUT_ADDR_WIDTH-1:0]            out_addr_o;
    logic [DATA_WIDTH-1:0]                out_data_o;
    logic                                 done_o;
    logic [OUT_ADDR_WIDTH-1:0]            digit_o;

    modport master (
        input  start_i, hid_q_i, wt_q_i,
        output hid_addr_o, wt_addr_o, busy_o, out_we_o, out_addr_o,
               out_data_o, done_o, digit_o
    );

    modport slave (
        output start_i, hid_q_i, wt_q_i,
        input  hid_addr_o, wt_addr_o, busy_o, out_we_o, out_addr_o,
               out_data_o, done_o, digit_o
    );
endinterface
`default_nettype wire

// File: rtl/output_layer_mac.sv
`default_nettype none
// ============================================================================
// Module   : output_layer_mac
// Brief    : Sequential MAC over 32 hidden units for 10 output neurons + argmax.
// Revision : 1.0
// ============================================================================
module output_layer_mac #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 5,
    parameter int NUM_OUT        = 10,
    parameter int OUT_ADDR_WIDTH = 4,
    parameter int ACC_WIDTH      = 24
) (
    input  wire logic          clk,
    input  wire logic          rst,
    output_layer_mac_if.master bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int                        PROD_WIDTH = 2 * DATA_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0]     LAST_HID   = {ADDR_WIDTH{1'b1}};
    localparam logic [OUT_ADDR_WIDTH-1:0] LAST_OUT   = OUT_ADDR_WIDTH'(NUM_OUT - 1);

    logic [2:0]                  state_q, state_d;
    logic [OUT_ADDR_WIDTH-1:0]   out_idx_q;
    logic [ADDR_WIDTH-1:0]       hid_idx_q;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic [DATA_WIDTH-1:0]       best_val_q;
    logic [OUT_ADDR_WIDTH-1:0]   best_idx_q;
    logic [OUT_ADDR_WIDTH-1:0]   digit_q;
    logic                        rd_valid_q;

    logic signed [PROD_WIDTH-1:0] prod_w;
    logic signed [ACC_WIDTH-1:0]  acc_sum_w;
    logic [DATA_WIDTH-1:0]        sat_w;

    // Activations are unsigned, so a zero MSB is prepended before the signed multiply.
    assign prod_w    = $signed({1'b0, bus.hid_q_i}) * $signed(bus.wt_q_i);
    assign acc_sum_w = acc_q + {{(ACC_WIDTH-PROD_WIDTH){prod_w[PROD_WIDTH-1]}}, prod_w};

    always_comb begin
        sat_w = acc_q[2*DATA_WIDTH-1:DATA_WIDTH];
        if (acc_q[ACC_WIDTH-1]) begin
            sat_w = '0;
        end else if (|acc_q[ACC_WIDTH-2:2*DATA_WIDTH]) begin
            sat_w = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start_i) state_d = S_ISSUE;
            S_ISSUE: if (hid_idx_q == LAST_HID) state_d = S_DRAIN;
            S_DRAIN: state_d = S_WRITE;
            S_WRITE: state_d = (out_idx_q == LAST_OUT) ? S_DONE : S_ISSUE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // hid_idx parks at the last address so hid_addr holds through DRAIN and WRITE.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_idx_q  <= '0;
            hid_idx_q  <= '0;
            acc_q      <= '0;
            best_val_q <= '0;
            best_idx_q <= '0;
            digit_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= (state_q == S_ISSUE);
            if (rd_valid_q) begin
                acc_q <= acc_sum_w;
            end
            case (state_q)
                S_IDLE: begin
                    if (bus.start_i) begin
                        out_idx_q  <= '0;
                        hid_idx_q  <= '0;
                        acc_q      <= '0;
                        best_val_q <= '0;
                        best_idx_q <= '0;
                    end
                end
                S_ISSUE: begin
                    if (hid_idx_q != LAST_HID) begin
                        hid_idx_q <= hid_idx_q + 1'b1;
                    end
                end
                S_WRITE: begin
                    acc_q     <= '0;
                    hid_idx_q <= '0;
                    if ((out_idx_q == '0) || (sat_w > best_val_q)) begin
                        best_val_q <= sat_w;
                        best_idx_q <= out_idx_q;
                    end
                    if (out_idx_q != LAST_OUT) begin
                        out_idx_q <= out_idx_q + 1'b1;
                    end
                end
                S_DONE: digit_q <= best_idx_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.busy_o     = (state_q != S_IDLE);
        bus.hid_addr_o = hid_idx_q;
        bus.wt_addr_o  = {out_idx_q, hid_idx_q};
        bus.out_we_o   = (state_q == S_WRITE);
        bus.out_addr_o = (state_q == S_WRITE) ? out_idx_q : '0;
        bus.out_data_o = (state_q == S_WRITE) ? sat_w : '0;
        bus.done_o     = (state_q == S_DONE);
        bus.digit_o    = (state_q == S_DONE) ? best_idx_q : digit_q;
    end
endmodule
`default_nettype wire

// File: doc/output_layer_mac.md
# output_layer_mac

Output-layer neuron engine for the digit classifier. It sits directly downstream of the 32-entry hidden-unit RAM. After the hidden layer is written, it reads the 32 hidden activations once per output neuron and multiplies each by a signed weight from the output weight memory. It accumulates the products, saturates each neuron's result to 8 bits, writes the results to the output-score store and reports the argmax digit.

## Interface
- DATA_WIDTH, 8, hidden activation and weight width
- ADDR_WIDTH, 5, hidden RAM address width (NUM_HIDDEN = 2**ADDR_WIDTH = 32)
- NUM_OUT, 10, number of output neurons
- OUT_ADDR_WIDTH, 4, output neuron index width
- ACC_WIDTH, 24, signed accumulator width

- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin one classification pass; ignored unless idle
- hid_addr  out  ADDR_WIDTH  read address to the hidden-unit RAM (the RAM registers it)
- hid_q  in  DATA_WIDTH  hidden activation, unsigned, valid one cycle after hid_addr
- wt_addr  out  OUT_ADDR_WIDTH+ADDR_WIDTH  {out_idx, hid_idx} to the weight memory (same 1-cycle registered-read timing)
- wt_q  in  DATA_WIDTH  weight, signed two's complement
- busy  out  1  high from the cycle after start is accepted until DONE, inclusive
- out_we  out  1  one-cycle write strobe per neuron
- out_addr  out  OUT_ADDR_WIDTH  neuron index for out_data
- out_data  out  DATA_WIDTH  saturated neuron score
- done  out  1  one-cycle pulse at end of pass
- digit  out  OUT_ADDR_WIDTH  index of the highest score; updated at DONE, held until the next DONE or reset

## Operation
- FSM states: IDLE, ISSUE, DRAIN, WRITE, DONE.
- IDLE
  - When start=1: clear out_idx, hid_idx, acc, best_val and best_idx; go to ISSUE.
- ISSUE
  - Drive hid_addr=hid_idx and wt_addr={out_idx,hid_idx}.
  - Set the rd_valid pipeline flag for the next cycle; increment hid_idx.
  - At hid_idx=31, go to DRAIN.
- Accumulate stage: in any cycle where rd_valid=1, acc += $signed({1'b0,hid_q}) * $signed(wt_q).
  - The product is 17-bit signed, sign-extended to ACC_WIDTH.
  - Accumulation occurs in ISSUE cycles 2..32 and in DRAIN.
- DRAIN: the last product (hid_idx 31) is accumulated; go to WRITE.
- WRITE
  - Set out_we=1, out_addr=out_idx, out_data=sat(acc).
  - If out_idx==0 or sat(acc) > best_val: best_val=sat(acc), best_idx=out_idx. Ties keep the lower index.
  - Clear acc and hid_idx.
  - If out_idx==NUM_OUT-1, go to DONE; otherwise increment out_idx and go to ISSUE.
- sat(acc):
  - acc<0 gives 0.
  - Otherwise, if (acc>>>8)>255, the result is 255.
  - Otherwise the result is acc[15:8] (truncating divide by 256).
- DONE: done=1, digit=best_idx; go to IDLE.
- start is ignored while busy.
- The block never drives the hidden RAM write port. The upstream writer must hold its we low while busy=1.

## Timing
- Reset values:
  - State: IDLE.
  - busy, done, out_we: 0.
  - hid_addr, wt_addr, out_addr, out_data, digit: 0.
  - acc and rd_valid: 0.
- Reset applies in any state, including mid-pass.
  - It aborts the pass; no further out_we pulses occur.
  - digit returns to 0.
- Cycle numbering: start is sampled at edge E0.
  - ISSUE occupies cycles 1–32 of neuron 0.
  - DRAIN is cycle 33; WRITE is cycle 34.
  - Neuron k WRITE is at cycle 34(k+1).
  - done is high in cycle 341; busy is high in cycles 1–341.
- Read latency: hid_q/wt_q in cycle n correspond to addresses driven in cycle n-1. hid_addr changes every ISSUE cycle, with no bubbles inside a neuron.
- Between neurons, hid_addr holds its last value during DRAIN and WRITE, and rd_valid=0.
- A back-to-back start in the cycle after done is accepted (state is IDLE).
- No overflow is possible: |acc| ≤ 32·255·128 = 1,044,480 < 2^23.

## Test plan
- All hidden=0, arbitrary weights, start → ten out_we pulses at cycles 34, 68…340, all out_data=0, done at cycle 341, digit=0.
- Hidden all 255; neuron 3 weights all +1; others 0 → acc=8160, out_data[3]=31, others 0, digit=3.
- Saturation: hidden all 255; neuron 7 weights +127 → out_data[7]=255, digit=7. Neuron 1 weights -128 → out_data[1]=0.
- Alignment: hid[i]=8·i; neuron 0 wt[31]=64, others 0 → out_data[0]=62. A value of 60 indicates an off-by-one latency error.
- Tie: neurons 2 and 5 both score 31, others 0 → digit=2.
- Control:
  - start pulsed at cycle 50 of a pass → ignored; done still at 341.
  - rst at cycle 100 → busy=0 and out_we=0 next cycle, digit=0.
  - A fresh start then yields correct scores.
